// File: rtl/color_ram_arbiter.sv
// Arbiter for the single-port 1Kx4 color RAM. VIC c-access reads always win and return
// one cycle later; CPU accesses are latched and issued in the first cycle without a VIC read.
module color_ram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 4,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vic_req,
  input  logic [ADDR_W-1:0] vic_addr,
  output logic              vic_valid,
  output logic [DATA_W-1:0] vic_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              starve_err,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        dbg_state
);

  // Handshake: a cpu_req is taken only in a cycle where cpu_busy=0; exactly one
  // cpu_ack pulse follows each taken request, and cpu_busy is low in that ack cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] STARVE_LIM = WAIT_W'(STARVE_MAX);

  state_t              state_q, state_d;
  logic                vic_valid_q, vic_valid_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                starve_q, starve_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                pend_we_q, pend_we_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]   pend_wdata_q, pend_wdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      vic_valid_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      starve_q     <= 1'b0;
      wait_q       <= '0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      vic_valid_q  <= vic_valid_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vic_valid_d  = vic_req;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    starve_d     = starve_q;
    wait_d       = wait_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          pend_we_d    = cpu_we;
          pend_addr_d  = cpu_addr;
          pend_wdata_d = cpu_wdata;
          wait_d       = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (vic_req) begin
          // Deferred again; the access stays queued even after starvation is flagged.
          if (wait_q != STARVE_LIM) wait_d = wait_q + 1'b1;
          if (wait_d == STARVE_LIM) starve_d = 1'b1;
        end else if (pend_we_q) begin
          cpu_ack_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        // ram_dout holds the CPU read now, so a VIC read may use the RAM this cycle.
        cpu_rdata_d = ram_dout;
        cpu_ack_d   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = pend_addr_q;
    ram_din = pend_wdata_q;
    if (vic_req) begin
      ram_ce = 1'b1;
      ram_ad = vic_addr;
    end else if (state_q == ISSUE) begin
      ram_ce  = 1'b1;
      ram_wre = pend_we_q;
    end
  end

  assign ram_oce    = 1'b1;
  assign ram_reset  = reset;
  assign vic_valid  = vic_valid_q;
  assign vic_data   = ram_dout;
  assign cpu_busy   = (state_q != IDLE);
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign starve_err = starve_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_color_ram_arbiter.sv
// Bench for color_ram_arbiter: a behavioural 1Kx4 RAM plus a transaction-level model
// of VIC reads and CPU accesses, checked every cycle.
module tb_color_ram_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 4;
  localparam int STARVE_MAX = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              vic_req;
  logic [ADDR_W-1:0] vic_addr;
  logic              vic_valid;
  logic [DATA_W-1:0] vic_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              starve_err;
  logic              ram_ce;
  logic              ram_oce;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic              ram_reset;
  logic [DATA_W-1:0] ram_dout;
  logic [1:0]        dbg_state;

  color_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .vic_req(vic_req), .vic_addr(vic_addr), .vic_valid(vic_valid), .vic_data(vic_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .starve_err(starve_err),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_reset(ram_reset), .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // ---------------- behavioural RAM ----------------
  logic              preload;
  logic [DATA_W-1:0] ram_mem [1024];

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 1024; k++) ram_mem[k] <= DATA_W'(k);
    end else if (ram_ce && ram_wre) begin
      ram_mem[ram_ad] <= ram_din;
    end
  end

  always @(posedge clk or posedge ram_reset) begin
    if (ram_reset) ram_dout <= '0;
    else if (ram_ce && !ram_wre) ram_dout <= ram_mem[ram_ad];
  end

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] ref_mem [1024];
  logic [DATA_W-1:0] exp_q[$];
  logic              prev_vr;
  logic              m_pend, m_we, m_ack_rd, m_starve;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd, m_rd_val, m_rdata;
  int                m_ack_at, m_wait;

  int   last_ack_cyc, busy_cnt, valid_run, max_run, watch_hits;
  logic watch_en;
  logic [ADDR_W-1:0] watch_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    prev_vr  = 1'b0;
    m_pend   = 1'b0;
    m_we     = 1'b0;
    m_ack_rd = 1'b0;
    m_starve = 1'b0;
    m_addr   = '0;
    m_wd     = '0;
    m_rd_val = '0;
    m_rdata  = '0;
    m_ack_at = -1;
    m_wait   = 0;
  endtask

  // ---------------- driver: one clock cycle with checks ----------------
  task automatic cycle(input logic vr, input logic [ADDR_W-1:0] va, input logic cr,
                       input logic cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd);
    logic              exp_busy, exp_ack;
    logic [DATA_W-1:0] exp_vd;
    @(posedge clk); #1;
    vic_req = vr; vic_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    cyc++;
    @(negedge clk);
    exp_busy = m_pend || (m_ack_at > cyc);
    exp_ack  = (m_ack_at == cyc);
    if (exp_ack && m_ack_rd) m_rdata = m_rd_val;

    chk("vic_valid", 32'(vic_valid), 32'(prev_vr));
    if (prev_vr) begin
      exp_vd = exp_q.pop_front();
      chk("vic_data", 32'(vic_data), 32'(exp_vd));
    end
    chk("cpu_busy", 32'(cpu_busy), 32'(exp_busy));
    chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
    chk("starve_err", 32'(starve_err), 32'(m_starve));
    chk("ram_oce", 32'(ram_oce), 32'd1);
    chk("ram_reset", 32'(ram_reset), 32'd0);
    if (vr) begin
      chk("ram_ce_vic", 32'(ram_ce), 32'd1);
      chk("ram_wre_vic", 32'(ram_wre), 32'd0);
      chk("ram_ad_vic", 32'(ram_ad), 32'(va));
    end else if (m_pend) begin
      chk("ram_ce_cpu", 32'(ram_ce), 32'd1);
      chk("ram_wre_cpu", 32'(ram_wre), 32'(m_we));
      chk("ram_ad_cpu", 32'(ram_ad), 32'(m_addr));
      if (m_we) chk("ram_din_cpu", 32'(ram_din), 32'(m_wd));
    end else begin
      chk("ram_ce_idle", 32'(ram_ce), 32'd0);
      chk("ram_wre_idle", 32'(ram_wre), 32'd0);
    end

    if (cpu_busy) busy_cnt++;
    if (cpu_ack) last_ack_cyc = cyc;
    if (vic_valid) valid_run++; else valid_run = 0;
    if (valid_run > max_run) max_run = valid_run;
    if (watch_en && ram_ce && ram_ad == watch_addr) watch_hits++;

    // Model: a pending access issues in the first cycle with no VIC read.
    if (m_pend) begin
      if (vr) begin
        if (m_wait < STARVE_MAX) m_wait++;
        if (m_wait == STARVE_MAX) m_starve = 1'b1;
      end else begin
        m_pend = 1'b0;
        if (m_we) begin
          ref_mem[m_addr] = m_wd;
          m_ack_at = cyc + 1;
          m_ack_rd = 1'b0;
        end else begin
          m_rd_val = ref_mem[m_addr];
          m_ack_at = cyc + 2;
          m_ack_rd = 1'b1;
        end
      end
    end else if (cr && !exp_busy) begin
      m_pend = 1'b1;
      m_we   = cw;
      m_addr = ca;
      m_wd   = cd;
      m_wait = 0;
    end
    if (vr) exp_q.push_back(ref_mem[va]);
    prev_vr = vr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  int req_cyc, burst_end, nbad;

  initial begin
    reset = 1'b1; preload = 1'b1;
    vic_req = 1'b0; vic_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = DATA_W'(k);
    model_reset();
    last_ack_cyc = -1; busy_cnt = 0; valid_run = 0; max_run = 0;
    watch_en = 1'b0; watch_addr = '0; watch_hits = 0;

    #2;
    chk("rst_vic_valid", 32'(vic_valid), 32'd0);
    chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_starve", 32'(starve_err), 32'd0);
    chk("rst_ram_ce", 32'(ram_ce), 32'd0);
    chk("rst_ram_reset", 32'(ram_reset), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1; preload = 1'b0;
    @(posedge clk); #1; reset = 1'b0;

    // Write 0x005 <- 0xC, then read it back, no VIC traffic.
    busy_cnt = 0; req_cyc = cyc + 1;
    cycle(1'b0, '0, 1'b1, 1'b1, 10'h005, 4'hC);
    idle(4);
    chk("wr_ack_latency", 32'(last_ack_cyc - req_cyc), 32'd2);
    chk("wr_busy_cycles", 32'(busy_cnt), 32'd1);
    busy_cnt = 0; req_cyc = cyc + 1;
    cycle(1'b0, '0, 1'b1, 1'b0, 10'h005, 4'h0);
    idle(4);
    chk("rd_ack_latency", 32'(last_ack_cyc - req_cyc), 32'd3);
    chk("rd_busy_cycles", 32'(busy_cnt), 32'd2);
    chk("rd_data_005", 32'(cpu_rdata), 32'hC);

    // 40-cycle VIC burst over 0x000..0x027.
    max_run = 0;
    for (int k = 0; k < 40; k++) cycle(1'b1, ADDR_W'(k), 1'b0, 1'b0, '0, '0);
    idle(2);
    chk("vic_valid_run", 32'(max_run), 32'd40);

    // CPU read of 0x010 accepted in cycle 2 of a VIC burst over 0x100..0x127.
    watch_addr = 10'h010; watch_hits = 0; watch_en = 1'b1;
    for (int k = 0; k < 40; k++) cycle(1'b1, ADDR_W'(16'h100 + k), (k == 1), 1'b0, 10'h010, '0);
    watch_en = 1'b0; burst_end = cyc;
    idle(5);
    chk("burst_ad_no_cpu", 32'(watch_hits), 32'd0);
    chk("burst_rd_ack", 32'(last_ack_cyc - burst_end), 32'd3);
    chk("burst_rd_data", 32'(cpu_rdata), 32'h0);

    // CPU write starved by a 70-cycle VIC hold.
    cycle(1'b1, 10'h050, 1'b1, 1'b1, 10'h3F0, 4'h5);
    for (int k = 1; k < 70; k++) cycle(1'b1, ADDR_W'(16'h050 + k), 1'b0, 1'b0, '0, '0);
    chk("starve_set", 32'(starve_err), 32'd1);
    burst_end = cyc;
    idle(4);
    chk("starve_wr_ack", 32'(last_ack_cyc - burst_end), 32'd2);
    chk("starve_sticky", 32'(starve_err), 32'd1);

    // Request while busy is ignored; request in the ack cycle is taken.
    watch_addr = 10'h200; watch_hits = 0; watch_en = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0, 10'h020, '0);
    cycle(1'b0, '0, 1'b1, 1'b1, 10'h200, 4'hF);
    cycle(1'b0, '0, 1'b1, 1'b1, 10'h200, 4'hF);
    req_cyc = cyc + 1;
    cycle(1'b0, '0, 1'b1, 1'b1, 10'h201, 4'h7);
    chk("ack_cycle_ack", 32'(cpu_ack), 32'd1);
    idle(4);
    watch_en = 1'b0;
    chk("ignored_req_no_ram", 32'(watch_hits), 32'd0);
    chk("ack_cycle_req_acked", 32'(last_ack_cyc - req_cyc), 32'd2);

    // Reset while a write to 0x3E7 is held in ISSUE.
    cycle(1'b1, 10'h0AA, 1'b1, 1'b1, 10'h3E7, 4'hA);
    cycle(1'b1, 10'h0AB, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 10'h0AC, 1'b0, 1'b0, '0, '0);
    chk("pre_reset_busy", 32'(cpu_busy), 32'd1);
    vic_req = 1'b0; cpu_req = 1'b0; reset = 1'b1;
    #1;
    chk("mid_rst_vic_valid", 32'(vic_valid), 32'd0);
    chk("mid_rst_busy", 32'(cpu_busy), 32'd0);
    chk("mid_rst_ack", 32'(cpu_ack), 32'd0);
    chk("mid_rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("mid_rst_starve", 32'(starve_err), 32'd0);
    chk("mid_rst_ram_ce", 32'(ram_ce), 32'd0);
    chk("mid_rst_ram_reset", 32'(ram_reset), 32'd1);
    model_reset();
    @(posedge clk); #1; reset = 1'b0;
    last_ack_cyc = -1;
    idle(2);
    chk("aborted_wr_no_ack", 32'(last_ack_cyc), 32'hFFFF_FFFF);
    cycle(1'b0, '0, 1'b1, 1'b0, 10'h3E7, '0);
    idle(4);
    chk("after_rst_rd_3e7", 32'(cpu_rdata), 32'h7);

    // Randomized mixed traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) < 45), ADDR_W'($urandom_range(0, 1023)),
            ($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, 1023)), DATA_W'($urandom_range(0, 15)));
    end
    idle(4);

    nbad = 0;
    for (int k = 0; k < 1024; k++) if (ram_mem[k] !== ref_mem[k]) nbad++;
    chk("ram_image", 32'(nbad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
